snoop_bus_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer for the shared snoop bus and the single memory port used by NUM_CACHE MSI caches.
- Each cache raises a request carrying a coherence message (action, block address).
- The arbiter grants one cache, broadcasts the message to all caches for one cycle, and runs the memory access when the message needs one. It then pulses done to the winner and re-arbitrates.

---
 rtl/snoop_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snoop_bus_arbiter
//  Description : Round-robin arbiter and transaction sequencer for a shared
//                MSI snoop bus and a single memory port. Grants one cache,
//                broadcasts its message for one cycle, runs the memory access
//                when the message needs one, then pulses done to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
    parameter int NUM_CACHE   = 4,
    parameter int PROCBIT     = 2,
    parameter int ADDRESSBIT  = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CACHE-1:0]             req,
    input  logic [4*NUM_CACHE-1:0]           reqAction,
    input  logic [ADDRESSBIT*NUM_CACHE-1:0]  reqAddr,
    output logic [NUM_CACHE-1:0]             grant,
    output logic [NUM_CACHE-1:0]             done,
    output logic                             snoopValid,
    output logic [3:0]                       snoopAction,
    output logic [PROCBIT-1:0]               snoopProc,
    output logic [ADDRESSBIT-1:0]            snoopAddr,
    output logic                             memReq,
    output logic                             memRW,
    output logic [ADDRESSBIT-1:0]            memAddr,
    input  logic                             memAck,
    output logic                             busBusy,
    output logic                             timeoutErr
);

    localparam int                c_cnt_w    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);
    localparam logic [3:0]        c_readmiss  = 4'd1;
    localparam logic [3:0]        c_writemiss = 4'd2;
    localparam logic [3:0]        c_writeback = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BCAST = 2'd1,
        S_MEM   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PROCBIT-1:0]      id_q, id_d;
    logic [PROCBIT-1:0]      last_q, last_d;
    logic [3:0]              act_q, act_d;
    logic [ADDRESSBIT-1:0]   addr_q, addr_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic                    tout_q, tout_d;

    // Registered outputs and their next values
    logic [NUM_CACHE-1:0]    grant_q, grant_d;
    logic [NUM_CACHE-1:0]    done_q, done_d;
    logic                    sv_q, sv_d;
    logic [3:0]              sact_q, sact_d;
    logic [PROCBIT-1:0]      sproc_q, sproc_d;
    logic [ADDRESSBIT-1:0]   saddr_q, saddr_d;
    logic                    mreq_q, mreq_d;
    logic                    mrw_q, mrw_d;
    logic [ADDRESSBIT-1:0]   maddr_q, maddr_d;
    logic                    busy_q, busy_d;

    logic [3:0]              w_act  [NUM_CACHE];
    logic [ADDRESSBIT-1:0]   w_addr [NUM_CACHE];
    logic                    w_sel_found;
    logic [PROCBIT-1:0]      w_sel_id;
    logic [PROCBIT-1:0]      w_scan;
    logic                    w_needs_mem;

    // Split the flat per-cache buses into indexable arrays.
    for (genvar i = 0; i < NUM_CACHE; i++) begin : g_unpack
        assign w_act[i]  = reqAction[4*i+3 : 4*i];
        assign w_addr[i] = reqAddr[ADDRESSBIT*i+ADDRESSBIT-1 : ADDRESSBIT*i];
    end

    assign w_needs_mem = (act_q == c_readmiss) || (act_q == c_writemiss) ||
                         (act_q == c_writeback);

    // Round-robin pick: first set request after the last winner, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_scan      = '0;
        for (int k = 1; k <= NUM_CACHE; k++) begin
            w_scan = PROCBIT'((int'(last_q) + k) % NUM_CACHE);
            if (!w_sel_found && req[w_scan]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_scan;
            end
        end
    end

    // Next-state logic: sequencing plus the latched transaction and timeout.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        act_d   = act_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        case (state_q)
            S_IDLE: begin
                if (w_sel_found) begin
                    id_d    = w_sel_id;
                    act_d   = w_act[w_sel_id];
                    addr_d  = w_addr[w_sel_id];
                    state_d = S_BCAST;
                end
            end
            S_BCAST: begin
                cnt_d   = '0;
                state_d = w_needs_mem ? S_MEM : S_DONE;
            end
            S_MEM: begin
                if (memAck) begin
                    state_d = S_DONE;
                end else if (cnt_q == c_cnt_last) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        sv_d    = 1'b0;
        sact_d  = '0;
        sproc_d = '0;
        saddr_d = '0;
        mreq_d  = 1'b0;
        mrw_d   = 1'b0;
        maddr_d = '0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_BCAST: begin
                grant_d[id_d] = 1'b1;
                sv_d          = 1'b1;
                sact_d        = act_d;
                sproc_d       = id_d;
                saddr_d       = addr_d;
            end
            S_MEM: begin
                grant_d[id_d] = 1'b1;
                mreq_d        = 1'b1;
                mrw_d         = (act_d == c_writeback);
                maddr_d       = addr_d;
            end
            S_DONE: begin
                grant_d[id_d] = 1'b1;
                done_d[id_d]  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, transaction and output registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            last_q  <= PROCBIT'(NUM_CACHE - 1);
            act_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            sv_q    <= 1'b0;
            sact_q  <= '0;
            sproc_q <= '0;
            saddr_q <= '0;
            mreq_q  <= 1'b0;
            mrw_q   <= 1'b0;
            maddr_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            sv_q    <= sv_d;
            sact_q  <= sact_d;
            sproc_q <= sproc_d;
            saddr_q <= saddr_d;
            mreq_q  <= mreq_d;
            mrw_q   <= mrw_d;
            maddr_q <= maddr_d;
            busy_q  <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign snoopValid  = sv_q;
    assign snoopAction = sact_q;
    assign snoopProc   = sproc_q;
    assign snoopAddr   = saddr_q;
    assign memReq      = mreq_q;
    assign memRW       = mrw_q;
    assign memAddr     = maddr_q;
    assign busBusy     = busy_q;
    assign timeoutErr  = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snoop_bus_arbiter
//  Description : Self-checking bench for snoop_bus_arbiter. A transaction-level
//                model predicts the winner, broadcast, memory phase and done
//                pulse of every transaction from the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

    localparam int N  = 4;
    localparam int PB = 2;
    localparam int AB = 16;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [3:0]        act  [N];
    logic [AB-1:0]     addr [N];
    logic [4*N-1:0]    reqAction;
    logic [AB*N-1:0]   reqAddr;
    logic [N-1:0]      grant, done;
    logic              snoopValid;
    logic [3:0]        snoopAction;
    logic [PB-1:0]     snoopProc;
    logic [AB-1:0]     snoopAddr;
    logic              memReq, memRW;
    logic [AB-1:0]     memAddr;
    logic              memAck;
    logic              busBusy, timeoutErr;

    int                checks   = 0;
    int                failures = 0;
    int                m_last;
    logic              m_tout;
    logic [N-1:0]      bcast_grant;
    logic [N-1:0]      order [5];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign reqAction[4*i+3 : 4*i]       = act[i];
        assign reqAddr[AB*i+AB-1 : AB*i]    = addr[i];
    end

    snoop_bus_arbiter #(
        .NUM_CACHE(N), .PROCBIT(PB), .ADDRESSBIT(AB), .MEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .reqAction(reqAction), .reqAddr(reqAddr),
        .grant(grant), .done(done), .snoopValid(snoopValid), .snoopAction(snoopAction),
        .snoopProc(snoopProc), .snoopAddr(snoopAddr), .memReq(memReq), .memRW(memRW),
        .memAddr(memAddr), .memAck(memAck), .busBusy(busBusy), .timeoutErr(timeoutErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string ph, input logic [N-1:0] g, input logic [N-1:0] d,
                              input logic sv, input logic [3:0] sa, input logic [PB-1:0] sp,
                              input logic [AB-1:0] sad, input logic mr, input logic mw,
                              input logic [AB-1:0] mad, input logic busy);
        chk({ph, ".grant"},       grant,       g);
        chk({ph, ".done"},        done,        d);
        chk({ph, ".snoopValid"},  snoopValid,  sv);
        chk({ph, ".snoopAction"}, snoopAction, sa);
        chk({ph, ".snoopProc"},   snoopProc,   sp);
        chk({ph, ".snoopAddr"},   snoopAddr,   sad);
        chk({ph, ".memReq"},      memReq,      mr);
        chk({ph, ".memRW"},       memRW,       mw);
        chk({ph, ".memAddr"},     memAddr,     mad);
        chk({ph, ".busBusy"},     busBusy,     busy);
        chk({ph, ".timeoutErr"},  timeoutErr,  m_tout);
    endtask

    // Winner: first requester after the previous winner, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit needs_mem(input logic [3:0] a);
        return (a == 4'd1) || (a == 4'd2) || (a == 4'd4);
    endfunction

    // Called during an IDLE cycle with req/act/addr already set up; the next
    // edge samples them. ack_delay < 0 means memory never acknowledges.
    task automatic do_txn(input int ack_delay, input bit drop, input bit scramble);
        int            w;
        logic [3:0]    a;
        logic [AB-1:0] ad;
        w = pick(req, m_last);
        if (w < 0) begin
            @(posedge clk); #1;
            expect_out("idle", '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
            return;
        end
        a  = act[w];
        ad = addr[w];
        @(posedge clk); #1;
        bcast_grant = grant;
        expect_out("bcast", N'(1) << w, '0, 1'b1, a, PB'(w), ad, 1'b0, 1'b0, '0, 1'b1);
        if (scramble) begin
            for (int i = 0; i < N; i++) begin
                act[i]  = 4'($urandom);
                addr[i] = AB'($urandom);
            end
        end
        memAck = 1'($urandom);
        if (needs_mem(a)) begin
            for (int c = 0; c < TO; c++) begin
                @(posedge clk); #1;
                expect_out("mem", N'(1) << w, '0, 1'b0, '0, '0, '0, 1'b1, (a == 4'd4), ad, 1'b1);
                memAck = (c == ack_delay);
                if (c == ack_delay) break;
                if (c == TO - 1) m_tout = 1'b1;
            end
        end
        @(posedge clk); #1;
        expect_out("done", N'(1) << w, N'(1) << w, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        memAck = 1'($urandom);
        if (drop) req[w] = 1'b0;
        @(posedge clk); #1;
        expect_out("post", '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        memAck = 1'b0;
        m_last = w;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        memAck = 1'b0;
        m_tout = 1'b0;
        #1;
        expect_out("reset", '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        m_last = N - 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req    = '0;
        memAck = 1'b0;
        m_tout = 1'b0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            act[i]  = '0;
            addr[i] = '0;
        end
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        repeat (2) @(negedge clk);
        do_reset();

        // Single INVALIDATE from cache 0, then an idle cycle.
        req = 4'b0001; act[0] = 4'd3; addr[0] = 16'h1234;
        do_txn(-1, 1'b1, 1'b1);
        do_txn(0, 1'b1, 1'b1);

        // READMISS from cache 2, acknowledged in the fifth memory cycle.
        req = 4'b0100; act[2] = 4'd1; addr[2] = 16'h00A0;
        do_txn(4, 1'b1, 1'b1);

        // Four continuous WRITEBACK requesters rotate 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            act[i]  = 4'd4;
            addr[i] = AB'(16'h4000 + i);
        end
        for (int t = 0; t < 5; t++) begin
            do_txn(2, 1'b0, 1'b0);
            chk("rr_order", bcast_grant, order[t]);
        end
        req = '0;

        // Memory never acknowledges: timeout, sticky error, then normal service.
        req = 4'b0010; act[1] = 4'd1; addr[1] = 16'hBEEF;
        do_txn(-1, 1'b1, 1'b1);
        req = 4'b1000; act[3] = 4'd2; addr[3] = 16'h0F0F;
        do_txn(1, 1'b1, 1'b1);

        // Asynchronous reset while cache 1 is in its memory phase.
        req = 4'b0010; act[1] = 4'd1; addr[1] = 16'h2222;
        @(posedge clk); #1;
        chk("abort.bcast_grant", grant, 4'b0010);
        @(posedge clk); #1;
        chk("abort.memReq", memReq, 1'b1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        m_tout = 1'b0;
        #1;
        expect_out("async_reset", '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        m_last = N - 1;
        req = 4'b0011; act[0] = 4'd3; act[1] = 4'd2; addr[0] = 16'h0100; addr[1] = 16'h0101;
        do_txn(0, 1'b1, 1'b0);
        chk("abort.first_winner", bcast_grant, 4'b0001);
        do_txn(3, 1'b1, 1'b1);

        // Unknown message code 7 behaves as a no-memory broadcast.
        req = 4'b1000; act[3] = 4'd7; addr[3] = 16'h7777;
        do_txn(0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                act[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
                addr[i] = AB'($urandom);
            end
            do_txn(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
